// File: rtl/wb_ps2_pkg.sv
// wb_ps2_pkg: register offsets, STATUS/CTRL bit positions and the receiver
// state type shared by the PS/2 receiver block.
package wb_ps2_pkg;

  // Register offsets (adr_i[1:0])
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_ERR_PAR  = 3;
  localparam int ST_ERR_FRM  = 4;
  localparam int ST_FLUSH    = 7;  // write-only: flush the FIFO

  // CTRL bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_RX_EN  = 1;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/wb_ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous byte FIFO for received PS/2 bytes.
// A pop on empty is ignored; a push on full succeeds only with a same-cycle
// pop. Flush empties the FIFO and wins over a concurrent push/pop.
module ps2_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write
  // NOTE: the storage array has no reset; only pointers/count define validity,
  // which keeps the array as plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers and fill count; pointers wrap naturally since DEPTH is a power of two
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wb_ps2.sv
// wb_ps2: Wishbone slave PS/2 receiver (device-to-host frames only).
// Optional build macro PS2_GLITCH_FILTER_EN adds a FILTER_LEN-cycle stability
// filter on the synchronised ps2_clk before falling-edge detection.
module wb_ps2
  import wb_ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          ps2_clk_s, ps2_dat_s;
  logic          clk_level, clk_prev, ps2_fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          rx_push, set_par, set_frm;

  logic          irq_en, rx_en;
  logic          overflow, err_par, err_frm;

  logic          fifo_full, fifo_empty, flush, rd_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  logic          req, wr, st_wr, ctrl_wr, ovf_set;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{adr_i[29:2], sel_i[3:1], dat_i[31:8], dat_i[6:5]};

  // Two-flop synchronisers; idle-high reset so no false edge comes out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  assign ps2_clk_s = clk_sync[1];
  assign ps2_dat_s = dat_sync[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt;

  // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_level <= 1'b1;
      filt_cnt  <= '0;
    end else if (ps2_clk_s == clk_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_level <= ps2_clk_s;
      filt_cnt  <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN != 0);
  assign clk_level = ps2_clk_s;
`endif

  // Previous clock level for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) clk_prev <= 1'b1;
    else       clk_prev <= clk_level;
  end

  assign ps2_fall = clk_prev & ~clk_level;

  // Frame receiver: start, 8 data LSB first, odd parity, stop; timeout abandons partial frames
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      timer   <= '0;
      rx_push <= 1'b0;
      set_par <= 1'b0;
      set_frm <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      set_par <= 1'b0;
      set_frm <= 1'b0;
      if (!rx_en) begin
        state   <= IDLE;
        bit_cnt <= '0;
        timer   <= '0;
      end else if (ps2_fall) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (!ps2_dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              set_frm <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {ps2_dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= ps2_dat_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!ps2_dat_s)                        set_frm <= 1'b1;
            else if (!odd_parity_ok(shreg, par_bit)) set_par <= 1'b1;
            else                                   rx_push <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timer == TW'(TIMEOUT)) begin
          state   <= IDLE;
          bit_cnt <= '0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (rx_push),
    .din   (shreg),
    .pop   (rd_pop),
    .flush (flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus decode: requests are acked next cycle; writes take effect in the ack cycle
  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr      = ack_o & cyc_i & stb_i & we_i & sel_i[0];
  assign st_wr   = wr & (adr_i[1:0] == REG_STATUS);
  assign ctrl_wr = wr & (adr_i[1:0] == REG_CTRL);
  assign flush   = st_wr & dat_i[ST_FLUSH];
  assign ovf_set = rx_push & fifo_full & ~rd_pop;

  // Read mux, captured at request time and presented with ack
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rdata = '0;
    case (adr_i[1:0])
      REG_RXDATA: if (!fifo_empty) rdata[8:0] = {1'b1, fifo_dout};
      REG_STATUS: begin
        rdata[ST_NONEMPTY] = ~fifo_empty;
        rdata[ST_FULL]     = fifo_full;
        rdata[ST_OVERFLOW] = overflow;
        rdata[ST_ERR_PAR]  = err_par;
        rdata[ST_ERR_FRM]  = err_frm;
        rdata[15:8]        = 8'(fifo_count);
      end
      REG_CTRL: begin
        rdata[CTRL_IRQ_EN] = irq_en;
        rdata[CTRL_RX_EN]  = rx_en;
      end
      default: rdata = '0;
    endcase
  end

  // Bus response registers; the pop is armed only if the returned byte was valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      rd_pop <= 1'b0;
    end else begin
      ack_o  <= req;
      dat_o  <= req ? rdata : '0;
      rd_pop <= req & ~we_i & (adr_i[1:0] == REG_RXDATA) & ~fifo_empty;
    end
  end

  // Control register and sticky flags; a same-cycle set beats a W1C clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en   <= 1'b0;
      rx_en    <= 1'b1;
      overflow <= 1'b0;
      err_par  <= 1'b0;
      err_frm  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= dat_i[CTRL_IRQ_EN];
        rx_en  <= dat_i[CTRL_RX_EN];
      end
      overflow <= ovf_set | (overflow & ~(st_wr & dat_i[ST_OVERFLOW]));
      err_par  <= set_par | (err_par  & ~(st_wr & dat_i[ST_ERR_PAR]));
      err_frm  <= set_frm | (err_frm  & ~(st_wr & dat_i[ST_ERR_FRM]));
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= irq_en & (~fifo_empty | overflow);
  end

endmodule

// File: tb/tb_wb_ps2.sv
// tb_wb_ps2: directed bench for wb_ps2 with a byte scoreboard. Received bytes
// are queued when a well-formed frame is driven and compared on RXDATA pops.
module tb_wb_ps2;

  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 200;
  localparam int HALF       = 20;   // ps2_clk half period in sys clocks

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i;
  logic [29:0] adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        ps2_clk, ps2_dat;
  logic        irq_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  logic        last_ack2;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_ps2 #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .FILTER_LEN(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .sel_i   (sel_i),
    .dat_i   (dat_i),
    .ack_o   (ack_o),
    .dat_o   (dat_o),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .irq_o   (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input string tag, input logic [1:0] a, input logic w,
                          input logic [31:0] d, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = '0;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = {28'b0, a}; sel_i = 4'h1; dat_i = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        got = 1'b1;
        q   = dat_o;
        break;
      end
    end
    check({tag, "_ack"}, {31'b0, got}, 32'd1);
    if (got) begin
      @(posedge clk); #1;
      last_ack2 = ack_o;
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_read(input string tag, input logic [1:0] a, output logic [31:0] q);
    wb_cycle(tag, a, 1'b0, 32'h0, q);
  endtask

  task automatic wb_write(input string tag, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(tag, a, 1'b1, d, dummy);
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_read(tag, a, q);
    check(tag, q, exp);
  endtask

  // Pop RXDATA and compare against the scoreboard head (0 when nothing expected)
  task automatic pop_check(input string tag);
    logic [31:0] q, exp;
    wb_read(tag, 2'd0, q);
    if (exp_q.size() == 0) exp = 32'h0;
    else                   exp = {23'b0, 1'b1, exp_q.pop_front()};
    check(tag, q, exp);
  endtask

  // One PS/2 bit: data set while clock high, then a low half period.
  // With glitch set, a 3-cycle low pulse is injected in the high phase.
  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cycles(6);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 9);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch, input logic expect_store);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(~bad_stop, glitch);
    ps2_dat = 1'b1;
    wait_cycles(HALF);
    if (expect_store) exp_q.push_back(b);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; sel_i = '0; dat_i = '0;
    ps2_clk = 1'b1; ps2_dat = 1'b1; last_ack2 = 1'b0;
    wait_cycles(3);
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    rst_i = 1'b0;
    wait_cycles(2);
    read_check("rst_status", 2'd1, 32'h0000);
    read_check("rst_ctrl",   2'd2, 32'h0002);

    // Good frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    read_check("good_status", 2'd1, 32'h0101);
    pop_check("good_rx");
    pop_check("empty_rx");

    // Parity error then W1C
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    read_check("par_status", 2'd1, 32'h0008);
    wb_write("par_clr", 2'd1, 32'h08);
    read_check("par_cleared", 2'd1, 32'h0000);

    // Stop-bit error then W1C
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    read_check("frm_status", 2'd1, 32'h0010);
    wb_write("frm_clr", 2'd1, 32'h10);
    read_check("frm_cleared", 2'd1, 32'h0000);

    // Receiver disabled: frame ignored
    wb_write("rxdis", 2'd2, 32'h0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    read_check("rxdis_status", 2'd1, 32'h0000);
    wb_write("rxen", 2'd2, 32'h2);

    // Nine frames into an 8-deep FIFO: ninth dropped, overflow set
    for (int i = 0; i < 9; i++)
      send_frame(8'(8'h21 + i * 8'h13), 1'b0, 1'b0, 1'b0, (i < FIFO_DEPTH));
    read_check("ovf_status", 2'd1, 32'h0807);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("ovf_pop");
    read_check("ovf_drained", 2'd1, 32'h0004);
    wb_write("ovf_clr", 2'd1, 32'h04);
    read_check("ovf_cleared", 2'd1, 32'h0000);

    // Partial frame abandoned by timeout, then a clean 0xF0
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_cycles(TIMEOUT + 10);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    read_check("tmo_status", 2'd1, 32'h0101);
    pop_check("tmo_rx");

    // Flush
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    read_check("pre_flush", 2'd1, 32'h0201);
    wb_write("flush", 2'd1, 32'h80);
    exp_q.delete();
    read_check("post_flush", 2'd1, 32'h0000);
    pop_check("flush_rx");

    // Reserved register: reads 0, acked, no back-to-back ack, writes ignored
    read_check("rsvd_read", 2'd3, 32'h0);
    check("no_b2b_ack", {31'b0, last_ack2}, 32'd0);
    wb_write("rsvd_write", 2'd3, 32'hFFFF_FFFF);
    read_check("rsvd_ctrl", 2'd2, 32'h0002);

    // Interrupt and mid-frame reset
    wb_write("irq_en", 2'd2, 32'h3);
    read_check("irq_ctrl", 2'd2, 32'h0003);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_cycles(2);
    check("irq_set", {31'b0, irq_o}, 32'd1);
    pop_check("irq_rx");
    wait_cycles(2);
    check("irq_clr", {31'b0, irq_o}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    check("irq_set2", {31'b0, irq_o}, 32'd1);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_dat = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b0;
    wait_cycles(2);
    rst_i = 1'b1;
    #1;
    check("mrst_ack", {31'b0, ack_o}, 32'd0);
    check("mrst_dat", dat_o, 32'd0);
    check("mrst_irq", {31'b0, irq_o}, 32'd0);
    exp_q.delete();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cycles(4);
    rst_i = 1'b0;
    wait_cycles(3);
    read_check("mrst_status", 2'd1, 32'h0000);
    read_check("mrst_ctrl",   2'd2, 32'h0002);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("post_rst_rx");

`ifdef PS2_GLITCH_FILTER_EN
    // Glitches on ps2_clk are rejected by the filter
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    read_check("glitch_status", 2'd1, 32'h0101);
    pop_check("glitch_rx");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_ps2.md
Name: wb_ps2

Overview:
Wishbone slave PS/2 keyboard/mouse receiver on the peripheral arbiter, alongside wb_uart.
- Samples the ps2_clk/ps2_dat pins and deserialises 11-bit device-to-host frames.
- Queues received bytes in a small FIFO.
- Exposes data/status/control registers and a level interrupt to the CPU interface.
- Receive only; host-to-device transmit is out of scope.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries (power of two, 2..64)
TIMEOUT, 50000, sys clock cycles without a ps2_clk falling edge before a partial frame is discarded
FILTER_LEN, 8, cycles a synchronised ps2_clk level must be stable to be accepted (filter build only)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
cyc_i  in  1  wishbone cycle
stb_i  in  1  wishbone strobe (decoded select from the arbiter)
we_i  in  1  write enable
adr_i  in  30  word address; only adr_i[1:0] decoded
sel_i  in  4  byte selects; writes honour sel_i[0] only
dat_i  in  32  write data
ack_o  out  1  single-cycle acknowledge
dat_o  out  32  read data, valid while ack_o=1
ps2_clk  in  1  PS/2 clock pin (asynchronous)
ps2_dat  in  1  PS/2 data pin (asynchronous)
irq_o  out  1  level interrupt

Behaviour:
- Reset:
  - ack_o=0, dat_o=0, irq_o=0.
  - FIFO empty, all sticky flags clear.
  - CTRL.rx_en=1, CTRL.irq_en=0.
  - Receiver in IDLE with bit count 0.
- Synchronisation: 2-flop synchroniser on each pin. A bit is sampled on the synchronised ps2_clk 1->0 transition.
- Receiver FSM:
  - IDLE: on falling edge, if dat=0 go to DATA, else set err_frm and stay.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on dat=1 with odd parity correct, push the byte.
  - Parity wrong: set err_par, discard the byte.
  - Stop bit=0: set err_frm, discard the byte.
  - All three outcomes return to IDLE.
- Timeout: a timer counts cycles since the last falling edge while not in IDLE. At TIMEOUT the FSM returns to IDLE with no flag set.
- rx_en=0: FSM held in IDLE and timer cleared. The FIFO is still readable.
- Wishbone timing:
  - ack_o asserted exactly one cycle after a cycle with cyc_i&stb_i&~ack_o. Zero wait states beyond that; no back-to-back ack.
  - Write side effects occur in the ack cycle.
- Register map (adr_i[1:0]):
  - 0 RXDATA, read:
    - [7:0] head byte, [8] valid.
    - Non-empty read pops in the ack cycle.
    - Empty read returns 0 and does not pop.
    - Writes are ignored.
  - 1 STATUS, read:
    - [0] nonempty, [1] full, [2] overflow, [3] err_par, [4] err_frm, [15:8] fill count.
    - Write with sel_i[0]: bits 2..4 are write-1-to-clear; dat_i[7]=1 flushes the FIFO.
  - 2 CTRL, read/write: [0] irq_en, [1] rx_en.
  - 3 reserved: reads 0, writes ignored, still acked.
- FIFO behaviour:
  - Push while full with no simultaneous pop: byte dropped, overflow set.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- Priority: a flag event in the same cycle as its W1C clear leaves the flag set. Set wins over clear.
- irq_o = irq_en & (nonempty | overflow), registered (one-cycle lag).

Optional Feature:
PS2_GLITCH_FILTER_EN:
- Defined:
  - The synchronised ps2_clk passes through a counter filter; the level changes only after FILTER_LEN consecutive equal samples.
  - Edge detection uses the filtered level.
  - Edge-to-sample latency is 2+FILTER_LEN cycles.
- Undefined: FILTER_LEN is unused and edges come straight from the synchroniser (latency 2).

Decomposition:
- Package wb_ps2_pkg:
  - Register offsets (REG_RXDATA=0, REG_STATUS=1, REG_CTRL=2).
  - STATUS/CTRL bit indices.
  - Receiver state enum (IDLE, DATA, PARITY, STOP).
- One sub-module, ps2_rx_fifo: synchronous FIFO with push/pop/flush/full/empty/count.
- The frame FSM stays in wb_ps2.

Test Plan:
- Frame 0x1C, parity 0, stop 1, ps2_clk period 4000 cycles -> STATUS=0x0101, RXDATA read returns 0x11C, next read returns 0x000.
- Frame 0x1C with parity 1 -> nothing pushed, STATUS[3]=1; write STATUS 0x08 -> STATUS[3]=0.
- Nine frames into FIFO_DEPTH=8 with no reads -> full=1, overflow=1, count=8, the ninth byte lost; pops return the first eight bytes in order.
- Five clock edges then silence for TIMEOUT+10 cycles, then a valid frame 0xF0 -> only 0xF0 received, no error flags.
- CTRL=0x3, one frame received -> irq_o=1; pop it -> irq_o=0 within 2 cycles; assert rst_i mid-frame -> all outputs return to reset values immediately.
- With PS2_GLITCH_FILTER_EN, FILTER_LEN=8: inject 3-cycle low glitches on ps2_clk during a 0xAA frame -> byte received as 0xAA, no err_frm.
